// File: rtl/riscv_pkg.sv
// Shared pipeline constants and the fetch-state encoding.
// Holds no logic, so it has no latency and no backpressure.
package riscv_pkg;

  localparam int          XLEN         = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register: valid/pc/pc4/instr, with bubble > load > hold. One cycle latency.
// Backpressure: when neither load nor bubble is asserted, every field holds its value.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         bubble,
  input  logic [W-1:0] pc_in,
  input  logic [W-1:0] pc4_in,
  input  logic [31:0]  instr_in,
  output logic         valid,
  output logic [W-1:0] pc,
  output logic [W-1:0] pc4,
  output logic [31:0]  instr
);

  logic         valid_q, valid_d;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] pc4_q, pc4_d;
  logic [31:0]  instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    if (bubble) begin
      valid_d = 1'b0;
      pc_d    = '0;
      pc4_d   = '0;
      instr_d = NOP_INSTR;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = pc_in;
      pc4_d   = pc4_in;
      instr_d = instr_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      pc4_q   <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign pc4   = pc4_q;
  assign instr = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, RUN/HALTED FSM and the IF/ID register. One-cycle fetch latency.
// Backpressure: stall holds PC, IF/ID and fetch_count; redirect always wins and restarts RUN.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int             XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc4,
  output logic [31:0]     if_id_instr,
  output logic            halted,
  output logic [31:0]     fetch_count
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     count_q, count_d;
  logic [XLEN-1:0] pc_plus4;
  logic            ifid_load;
  logic            ifid_bubble;

  // Natural XLEN-bit truncation gives the required wrap at the top of memory.
  assign pc_plus4 = pc_q + XLEN'(4);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    count_d     = count_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    if (redirect_valid) begin
      pc_d        = {redirect_pc[XLEN-1:2], 2'b00};
      ifid_bubble = 1'b1;
      state_d     = ST_RUN;
    end else if (state_q == ST_HALTED) begin
      ifid_bubble = 1'b1;
    end else if (!stall) begin
      ifid_load = 1'b1;
      count_d   = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;
      // EBREAK is still delivered downstream, but the PC parks on it.
      if (imem_rdata == EBREAK_INSTR) begin
        state_d = ST_HALTED;
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  if_id_reg #(
    .W (XLEN)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .load     (ifid_load),
    .bubble   (ifid_bubble),
    .pc_in    (pc_q),
    .pc4_in   (pc_plus4),
    .instr_in (imem_rdata),
    .valid    (if_id_valid),
    .pc       (if_id_pc),
    .pc4      (if_id_pc4),
    .instr    (if_id_instr)
  );

  assign imem_addr   = pc_q;
  assign halted      = (state_q == ST_HALTED);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, async-reset sequence, then random
// stimulus against a behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] EBRK = 32'h0010_0073;
  localparam logic [31:0] I0   = 32'h0010_0093;
  localparam logic [31:0] I1   = 32'h0020_0113;
  localparam logic [31:0] I2   = 32'h0030_0193;
  localparam logic [31:0] I3   = 32'h0040_0213;
  localparam logic [31:0] I63  = 32'h0050_0293;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] mem [64];
  assign imem_rdata = mem[imem_addr[7:2]];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_stage #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_pc4      (if_id_pc4),
    .if_id_instr    (if_id_instr),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_v,
                         input logic [31:0] e_ipc, input logic [31:0] e_ipc4,
                         input logic [31:0] e_instr, input logic e_h, input logic [31:0] e_cnt);
    chk({tag, ".imem_addr"},   imem_addr,           e_pc);
    chk({tag, ".if_id_valid"}, {31'd0, if_id_valid}, {31'd0, e_v});
    chk({tag, ".if_id_pc"},    if_id_pc,            e_ipc);
    chk({tag, ".if_id_pc4"},   if_id_pc4,           e_ipc4);
    chk({tag, ".if_id_instr"}, if_id_instr,         e_instr);
    chk({tag, ".halted"},      {31'd0, halted},     {31'd0, e_h});
    chk({tag, ".fetch_count"}, fetch_count,         e_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] e_pc;
    logic        e_v;
    logic [31:0] e_ipc;
    logic [31:0] e_ipc4;
    logic [31:0] e_instr;
    logic        e_h;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl [14];

  // Behavioural model state.
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_cnt;
  logic        m_v, m_h;

  task automatic model_reset();
    m_pc = 32'h0; m_v = 1'b0; m_ipc = 32'h0; m_ipc4 = 32'h0;
    m_instr = NOP; m_h = 1'b0; m_cnt = 32'h0;
  endtask

  task automatic model_step(input logic s, input logic rv, input logic [31:0] rpc);
    logic [31:0] w;
    w = mem[m_pc[7:2]];
    if (rv) begin
      m_pc = rpc & 32'hFFFF_FFFC;
      m_v = 1'b0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_instr = NOP;
      m_h = 1'b0;
    end else if (m_h) begin
      m_v = 1'b0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_instr = NOP;
    end else if (!s) begin
      m_v = 1'b1; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_instr = w;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (w == EBRK) m_h = 1'b1;
      else m_pc = m_pc + 32'd4;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = NOP;
    mem[0] = I0; mem[1] = I1; mem[2] = I2; mem[3] = I3; mem[4] = EBRK; mem[63] = I63;

    tbl[0]  = '{1'b0, 1'b0, 32'h0,         32'h4,         1'b1, 32'h0,         32'h4,   I0,   1'b0, 32'd1};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,         32'h8,         1'b1, 32'h4,         32'h8,   I1,   1'b0, 32'd2};
    tbl[2]  = '{1'b1, 1'b0, 32'h0,         32'h8,         1'b1, 32'h4,         32'h8,   I1,   1'b0, 32'd2};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,         32'h8,         1'b1, 32'h4,         32'h8,   I1,   1'b0, 32'd2};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,         32'hC,         1'b1, 32'h8,         32'hC,   I2,   1'b0, 32'd3};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,         32'h10,        1'b1, 32'hC,         32'h10,  I3,   1'b0, 32'd4};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,         32'h10,        1'b1, 32'h10,        32'h14,  EBRK, 1'b1, 32'd5};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,         32'h10,        1'b0, 32'h0,         32'h0,   NOP,  1'b1, 32'd5};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,         32'h10,        1'b0, 32'h0,         32'h0,   NOP,  1'b1, 32'd5};
    tbl[9]  = '{1'b0, 1'b1, 32'h40,        32'h40,        1'b0, 32'h0,         32'h0,   NOP,  1'b0, 32'd5};
    tbl[10] = '{1'b1, 1'b1, 32'h103,       32'h100,       1'b0, 32'h0,         32'h0,   NOP,  1'b0, 32'd5};
    tbl[11] = '{1'b0, 1'b0, 32'h0,         32'h104,       1'b1, 32'h100,       32'h104, I0,   1'b0, 32'd6};
    tbl[12] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b0, 32'h0,         32'h0,   NOP,  1'b0, 32'd6};
    tbl[13] = '{1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 32'hFFFF_FFFC, 32'h0,   I63,  1'b0, 32'd7};

    // Reset values while rst is held low, with the clock running.
    #12;
    chk_all("reset", 32'h0, 1'b0, 32'h0, 32'h0, NOP, 1'b0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;

    for (int i = 0; i < 14; i++) begin
      stall = tbl[i].stall;
      redirect_valid = tbl[i].rv;
      redirect_pc = tbl[i].rpc;
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_v, tbl[i].e_ipc,
              tbl[i].e_ipc4, tbl[i].e_instr, tbl[i].e_h, tbl[i].e_cnt);
    end
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Reach HALTED with fetch_count=5, then pull reset between edges.
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    chk("pre_arst.halted", {31'd0, halted}, 32'd1);
    chk("pre_arst.count", fetch_count, 32'd5);
    #3;
    rst = 1'b0;
    #1;
    chk_all("arst", 32'h0, 1'b0, 32'h0, 32'h0, NOP, 1'b0, 32'd0);
    #1;
    rst = 1'b1;
    tick();
    chk_all("post_arst", 32'h4, 1'b1, 32'h0, 32'h4, I0, 1'b0, 32'd1);

    // Random stimulus against the model.
    for (int i = 0; i < 64; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? EBRK : $urandom();
    do_reset();
    model_reset();
    #1;
    for (int c = 0; c < 2000; c++) begin
      stall = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 255));
      model_step(stall, redirect_valid, redirect_pc);
      tick();
      chk_all($sformatf("rand%0d", c), m_pc, m_v, m_ipc, m_ipc4, m_instr, m_h, m_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
